// File: rtl/demod_bit_logger_pkg.sv
// Shared types and width helpers for the demodulated-bit logger.
// Field widths of log_entry_t cover the largest legal configuration.
package demod_logger_pkg;

    localparam int MAX_CH_W   = 3;
    localparam int MAX_WORD_W = 32;
    localparam int MAX_CNT_W  = 64;

    typedef struct packed {
        logic [MAX_CH_W-1:0]   ch;
        logic [MAX_WORD_W-1:0] word;
        logic [MAX_CNT_W-1:0]  ts;
    } log_entry_t;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Occupancy must represent DEPTH itself, hence one bit beyond the address width.
    function automatic int level_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demod_bit_logger_fifo.sv
// First-word-fall-through FIFO for logger entries; head is zero while empty.
// Push is refused when full even if a pop happens in the same cycle.
module bit_log_fifo
    import demod_logger_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int ENT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          push,
    input  logic [ENT_W-1:0]              wr_data,
    input  logic                          pop,
    output logic [ENT_W-1:0]              rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = level_width(DEPTH);

    logic [ENT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/demod_bit_logger.sv
// Multi-channel demodulated-bit capture: per-channel packing, round-robin FIFO write, FWFT read.
// Define LOGGER_TS_EN to store a sample_count timestamp per entry and expose rd_ts.
module demod_bit_logger
    import demod_logger_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WORD_W = 16,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [NUM_CH-1:0]             update,
    input  logic [NUM_CH-1:0]             bit_in,
    input  logic                          rd_ready,
    output logic                          rd_valid,
    output logic [WORD_W-1:0]             rd_data,
    output logic [ch_width(NUM_CH)-1:0]   rd_ch,
`ifdef LOGGER_TS_EN
    output logic [CNT_W-1:0]              rd_ts,
`endif
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          overflow,
    output logic [CNT_W-1:0]              sample_count
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int BC_W  = $clog2(WORD_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
`ifdef LOGGER_TS_EN
    localparam int ENT_W = CH_W + WORD_W + CNT_W;
`else
    localparam int ENT_W = CH_W + WORD_W;
`endif

    logic [NUM_CH-1:0] update_q;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] pend_v;
    logic [WORD_W-2:0] shift_reg [NUM_CH];
    logic [BC_W-1:0]   bit_cnt   [NUM_CH];
    logic [WORD_W-1:0] pending   [NUM_CH];
`ifdef LOGGER_TS_EN
    logic [CNT_W-1:0]  pend_ts   [NUM_CH];
`endif

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   next_ptr;
    logic              gnt_v;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [ENT_W-1:0]  wr_ent;
    logic [ENT_W-1:0]  rd_ent;
    log_entry_t        wr_e;
    log_entry_t        head_e;
    logic              unused_entry_bits;

    // A held strobe only produces one rise; strobes during clear or disable are ignored.
    assign rise = update & ~update_q & {NUM_CH{enable & ~clear}};

    always_comb begin : rr_arb
        int j;
        gnt_v   = 1'b0;
        gnt_idx = '0;
        j       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = (int'(rr_ptr) + k) % NUM_CH;
            if (!gnt_v && pend_v[j]) begin
                gnt_v   = 1'b1;
                gnt_idx = CH_W'(j);
            end
        end
    end

    assign push     = gnt_v & ~fifo_full & ~clear;
    assign pop      = rd_ready & ~fifo_empty & ~clear;
    assign next_ptr = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;

    // Packing and pending-slot capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            update_q <= '0;
            pend_v   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shift_reg[i] <= '0;
                bit_cnt[i]   <= '0;
                pending[i]   <= '0;
`ifdef LOGGER_TS_EN
                pend_ts[i]   <= '0;
`endif
            end
        end else begin
            update_q <= update;
            if (clear) begin
                pend_v   <= '0;
                overflow <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    shift_reg[i] <= '0;
                    bit_cnt[i]   <= '0;
                    pending[i]   <= '0;
`ifdef LOGGER_TS_EN
                    pend_ts[i]   <= '0;
`endif
                end
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (push && gnt_idx == CH_W'(i)) begin
                        pend_v[i] <= 1'b0;
                    end
                    if (rise[i]) begin
                        shift_reg[i] <= (WORD_W-1)'({shift_reg[i], bit_in[i]});
                        if (bit_cnt[i] == LAST_BIT) begin
                            bit_cnt[i] <= '0;
                            // An occupied slot keeps its older word; the new one is lost.
                            if (pend_v[i]) begin
                                overflow <= 1'b1;
                            end else begin
                                pending[i] <= {shift_reg[i], bit_in[i]};
                                pend_v[i]  <= 1'b1;
`ifdef LOGGER_TS_EN
                                pend_ts[i] <= sample_count;
`endif
                            end
                        end else begin
                            bit_cnt[i] <= bit_cnt[i] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Round-robin pointer and free-running sample counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= '0;
            sample_count <= '0;
        end else if (clear) begin
            rr_ptr       <= '0;
            sample_count <= '0;
        end else begin
            if (enable) begin
                sample_count <= sample_count + 1'b1;
            end
            if (push) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    always_comb begin
        wr_e      = '0;
        wr_e.ch   = MAX_CH_W'(gnt_idx);
        wr_e.word = MAX_WORD_W'(pending[gnt_idx]);
`ifdef LOGGER_TS_EN
        wr_e.ts   = MAX_CNT_W'(pend_ts[gnt_idx]);
        wr_ent    = {wr_e.ch[CH_W-1:0], wr_e.word[WORD_W-1:0], wr_e.ts[CNT_W-1:0]};
`else
        wr_ent    = {wr_e.ch[CH_W-1:0], wr_e.word[WORD_W-1:0]};
`endif
    end

    bit_log_fifo #(
        .DEPTH (DEPTH),
        .ENT_W (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .push    (push),
        .wr_data (wr_ent),
        .pop     (pop),
        .rd_data (rd_ent),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (level)
    );

    always_comb begin
        head_e      = '0;
        head_e.ch   = MAX_CH_W'(rd_ent[ENT_W-1 -: CH_W]);
        head_e.word = MAX_WORD_W'(rd_ent[ENT_W-CH_W-1 -: WORD_W]);
`ifdef LOGGER_TS_EN
        head_e.ts   = MAX_CNT_W'(rd_ent[CNT_W-1:0]);
`endif
    end

    assign rd_valid = ~fifo_empty;
    assign rd_ch    = head_e.ch[CH_W-1:0];
    assign rd_data  = head_e.word[WORD_W-1:0];
`ifdef LOGGER_TS_EN
    assign rd_ts    = head_e.ts[CNT_W-1:0];
`endif

    // Struct fields are sized for the largest configuration; the spare bits are intentionally dropped.
    assign unused_entry_bits = ^{wr_e, head_e};

endmodule

// File: tb/tb_demod_bit_logger.sv
// Directed bench for demod_bit_logger (2 channels, 8-bit words, 4-deep FIFO).
module tb_demod_bit_logger;

    localparam int NUM_CH = 2;
    localparam int WORD_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              clear;
    logic [NUM_CH-1:0] update;
    logic [NUM_CH-1:0] bit_in;
    logic              rd_ready;
    logic              rd_valid;
    logic [WORD_W-1:0] rd_data;
    logic              rd_ch;
`ifdef LOGGER_TS_EN
    logic [CNT_W-1:0]  rd_ts;
`endif
    logic [2:0]        level;
    logic              overflow;
    logic [CNT_W-1:0]  sample_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demod_bit_logger #(
        .NUM_CH (NUM_CH),
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .update       (update),
        .bit_in       (bit_in),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ch        (rd_ch),
`ifdef LOGGER_TS_EN
        .rd_ts        (rd_ts),
`endif
        .level        (level),
        .overflow     (overflow),
        .sample_count (sample_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put_bit(input int ch, input logic b);
        update[ch] = 1'b1;
        bit_in[ch] = b;
        @(negedge clk);
        update[ch] = 1'b0;
        @(negedge clk);
    endtask

    task automatic put_word(input int ch, input logic [7:0] w);
        for (int b = 7; b >= 0; b--) begin
            put_bit(ch, w[b]);
        end
    endtask

    task automatic put_pair(input logic [7:0] w0, input logic [7:0] w1);
        for (int b = 7; b >= 0; b--) begin
            update = 2'b11;
            bit_in = {w1[b], w0[b]};
            @(negedge clk);
            update = 2'b00;
            @(negedge clk);
        end
    endtask

    task automatic pop_chk(input string tag, input logic exp_ch, input logic [7:0] exp_word);
        chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
        chk({tag, "_ch"}, 64'(rd_ch), 64'(exp_ch));
        chk({tag, "_data"}, 64'(rd_data), 64'(exp_word));
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        enable   = 1'b0;
        clear    = 1'b0;
        update   = '0;
        bit_in   = '0;
        rd_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_cnt", 64'(sample_count), 64'd0);
        rst    = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        // Word B2 on ch0, visibility two edges after the last bit
        put_bit(0, 1'b1); put_bit(0, 1'b0); put_bit(0, 1'b1); put_bit(0, 1'b1);
        put_bit(0, 1'b0); put_bit(0, 1'b0); put_bit(0, 1'b1);
        update[0] = 1'b1;
        bit_in[0] = 1'b0;
        @(negedge clk);
        update[0] = 1'b0;
        chk("t1_lat_e", 64'(rd_valid), 64'd0);
        @(negedge clk);
        chk("t1_lat_e1", 64'(rd_valid), 64'd1);
        chk("t1_level", 64'(level), 64'd1);
        pop_chk("t1", 1'b0, 8'hB2);
        chk("t1_empty", 64'(rd_valid), 64'd0);
        chk("t1_empty_data", 64'(rd_data), 64'd0);

        // Long strobe counts once
        update[0] = 1'b1;
        bit_in[0] = 1'b1;
        repeat (10) @(negedge clk);
        update[0] = 1'b0;
        bit_in[0] = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 6; n++) put_bit(0, 1'b0);
        chk("t2_partial_level", 64'(level), 64'd0);
        put_bit(0, 1'b0);
        chk("t2_level", 64'(level), 64'd1);
        pop_chk("t2", 1'b0, 8'h80);

        // Clear and enable gating of counter and strobes
        do_clear();
        enable    = 1'b0;
        update[0] = 1'b1;
        bit_in[0] = 1'b1;
        chk("clr_cnt", 64'(sample_count), 64'd0);
        @(negedge clk);
        update[0] = 1'b0;
        chk("dis_cnt", 64'(sample_count), 64'd0);
        enable = 1'b1;
        @(negedge clk);
        chk("en_cnt", 64'(sample_count), 64'd1);

        // Simultaneous completion, round-robin ordering
        put_pair(8'hA5, 8'h3C);
        chk("tie1_level_a", 64'(level), 64'd1);
        @(negedge clk);
        chk("tie1_level_b", 64'(level), 64'd2);
        pop_chk("tie1_first", 1'b0, 8'hA5);
        pop_chk("tie1_second", 1'b1, 8'h3C);
        put_word(0, 8'h11);
        pop_chk("lone", 1'b0, 8'h11);
        put_pair(8'h5A, 8'hC3);
        @(negedge clk);
        pop_chk("tie2_first", 1'b1, 8'hC3);
        pop_chk("tie2_second", 1'b0, 8'h5A);

        // Overflow with no reads
        for (int w = 1; w <= 5; w++) put_word(0, 8'(w));
        chk("ovf_level4", 64'(level), 64'd4);
        chk("ovf_pre", 64'(overflow), 64'd0);
        put_word(0, 8'h06);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_level_full", 64'(level), 64'd4);
        pop_chk("ovf_r1", 1'b0, 8'h01);
        pop_chk("ovf_r2", 1'b0, 8'h02);
        pop_chk("ovf_r3", 1'b0, 8'h03);
        pop_chk("ovf_r4", 1'b0, 8'h04);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        do_clear();
        chk("ovf_clr", 64'(overflow), 64'd0);
        chk("ovf_clr_level", 64'(level), 64'd0);
        chk("ovf_clr_valid", 64'(rd_valid), 64'd0);

        // Reset mid-word
        for (int n = 0; n < 5; n++) put_bit(0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(rd_valid), 64'd0);
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_data", 64'(rd_data), 64'd0);
        chk("mid_rst_ch", 64'(rd_ch), 64'd0);
        chk("mid_rst_cnt", 64'(sample_count), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        put_word(0, 8'h0F);
        chk("post_rst_level", 64'(level), 64'd1);
        pop_chk("post_rst", 1'b0, 8'h0F);
        chk("post_rst_empty", 64'(level), 64'd0);

`ifdef LOGGER_TS_EN
        begin
            int guard;
            guard = 0;
            do_clear();
            for (int n = 0; n < 7; n++) put_bit(0, 1'b1);
            while (sample_count != 32'd100 && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            chk("ts_wait", 64'(sample_count), 64'd100);
            put_bit(0, 1'b0);
            chk("ts_valid", 64'(rd_valid), 64'd1);
            chk("ts_value", 64'(rd_ts), 64'd100);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
